pwm_timebase_ctrl: RTL
======================

Name: pwm_timebase_ctrl

Overview:
Timebase and update sequencer for one PWM channel group, running in the prescaled clock domain. Generates the shared up-counter value and the update event that commits the compare values. Handles auto-reload shadowing, one-shot mode, update disable, and a software-forced update handshake from the I2C register block. Its outputs drive cnt_i and update_event_i of every pwm_comparator in the group.

Parameters:
WIDTH, 16, counter / auto-reload register width in bits

Ports:
clk_psc_i  in  1  prescaled clock; all logic on rising edge
rst_n_i  in  1  reset, synchronous, active-low
cnt_en_i  in  1  counter enable (level) from control register
one_shot_i  in  1  1 = stop after first wrap
udis_i  in  1  1 = suppress wrap-generated update events
arr_i  in  WIDTH  auto-reload (period-1) value, staged; takes effect only at update event
cfg_wr_i  in  1  1-cycle pulse: a compare/ARR register was written
sw_upd_req_i  in  1  software update request (level, req/ack handshake)
sw_upd_ack_o  out  1  1-cycle acknowledge of sw_upd_req_i
cnt_o  out  WIDTH  current counter value
update_event_o  out  1  1-cycle update event pulse
overflow_o  out  1  1-cycle wrap flag (independent of udis_i)
running_o  out  1  1 while state == RUN
upd_pending_o  out  1  staged config written but not yet committed

Behaviour:
- Clock and reset: one clock, clk_psc_i. Reset rst_n_i is synchronous and active-low.
- Reset (rst_n_i=0 at an edge): state=IDLE; cnt_o=0; arr_shadow=0; update_event_o, overflow_o, sw_upd_ack_o, upd_pending_o all 0; running_o=0; req_armed=1.
- Reset applied mid-period takes effect at the next edge with no final update event.
- All outputs are registered. update_event_o / overflow_o are high during the cycle in which cnt_o is 0 after the event. The comparator therefore latches new compare values on the following edge.
- FSM states: IDLE, RUN, STOP.
- IDLE:
  - cnt_o holds.
  - cnt_en_i=1 → RUN; cnt_o<=0; arr_shadow<=arr_i; update_event_o<=1 (init update, issued even if udis_i=1).
- RUN:
  - cnt_o<=cnt_o+1 while cnt_o<arr_shadow.
  - At cnt_o==arr_shadow: wrap, cnt_o<=0, overflow_o<=1.
  - If udis_i=0 at the wrap: update_event_o<=1 and arr_shadow<=arr_i.
  - If one_shot_i=1 at the wrap → STOP.
  - cnt_en_i=0 → IDLE with cnt_o frozen; no event.
- STOP: cnt_o=0; stays in STOP until cnt_en_i=0, then → IDLE. Restart needs a 0→1 on cnt_en_i.
- arr_shadow=0: wrap every cycle; overflow_o, and update_event_o if udis_i=0, stay high continuously.
- Software update:
  - When sw_upd_req_i=1 and req_armed=1 in any state: cnt_o<=0, arr_shadow<=arr_i, update_event_o<=1 (ignores udis_i), sw_upd_ack_o<=1, req_armed<=0. The state is unchanged, except STOP which goes → IDLE.
  - req_armed re-sets only after sw_upd_req_i is sampled 0. A held request yields exactly one ack.
- Priority in one cycle: reset > software update > cnt_en_i=0 (stop/freeze) > wrap.
- A software update coinciding with a wrap produces a single update_event_o pulse and overflow_o=0.
- upd_pending_o:
  - Set by cfg_wr_i.
  - Cleared when update_event_o is generated.
  - If cfg_wr_i coincides with an event-generating edge, upd_pending_o ends at 1.
- Width rules: unsigned compare cnt_o==arr_shadow. The increment never exceeds arr_shadow, so there is no natural overflow beyond 2^WIDTH-1. With arr_shadow = all-ones, wrap 0xFFFF→0 is via the compare.

Decomposition:
- pwm_pkg: state encoding localparams (IDLE/RUN/STOP), default WIDTH.
- One sub-module, pwm_tb_counter: counter, arr_shadow register, wrap detect, with inputs clear/load/run.
- FSM, handshake and pending logic live in pwm_timebase_ctrl.

Test Plan:
1. Reset, arr_i=4, cnt_en_i 0→1 → one update_event_o, then cnt_o 0,1,2,3,4,0; overflow_o and update_event_o pulse at each return to 0 (period 5).
2. Running with arr_i=4, change arr_i=9 at cnt_o=2 → current period still ends at 4; next period counts 0..9.
3. udis_i=1, arr_i=3, cfg_wr_i pulse → overflow_o every 4 cycles, no update_event_o, upd_pending_o stays 1; drop udis_i → next wrap gives update_event_o and clears upd_pending_o.
4. one_shot_i=1, arr_i=2 → counts 0,1,2,0 then running_o=0, STOP; cnt_en_i 1→0→1 → restarts with an init update_event_o.
5. sw_upd_req_i held high 6 cycles at cnt_o=3, arr=7 → single sw_upd_ack_o + update_event_o, cnt_o→0; second ack only after req low then high; request at a wrap edge → one event, overflow_o=0.
6. rst_n_i low for 1 cycle at cnt_o=5 → next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timebase: state encoding and default width.
package pwm_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        STOP = S_STOP
    } state_t;

endpackage

// File: rtl/pwm_tb_counter.sv
// Timebase counter with auto-reload shadow register and wrap detect.
// clear has priority over run; load commits the staged reload value.
module pwm_tb_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] arr_in,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] arr_shadow,
    output logic             wrap
);

    // Wrap is a pure compare; the counter is never incremented past the shadow.
    assign wrap = (cnt == arr_shadow);

    // Counter and shadow register update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            arr_shadow <= '0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (run)
                cnt <= cnt + 1'b1;
            if (load)
                arr_shadow <= arr_in;
        end
    end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM group timebase: run/stop FSM, software update handshake and
// pending-config tracking around the shared counter.
module pwm_timebase_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             cnt_en_i,
    input  logic             one_shot_i,
    input  logic             udis_i,
    input  logic [WIDTH-1:0] arr_i,
    input  logic             cfg_wr_i,
    input  logic             sw_upd_req_i,
    output logic             sw_upd_ack_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             update_event_o,
    output logic             overflow_o,
    output logic             running_o,
    output logic             upd_pending_o
);

    state_t           state, state_next;
    logic             clear, load, run;
    logic             wrap;
    logic [WIDTH-1:0] arr_shadow;
    logic             req_armed, armed_next;
    logic             sw_go;
    logic             evt_next, ovf_next, ack_next, pend_next;

    pwm_tb_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk_psc_i),
        .rst_n      (rst_n_i),
        .clear      (clear),
        .load       (load),
        .run        (run),
        .arr_in     (arr_i),
        .cnt        (cnt_o),
        .arr_shadow (arr_shadow),
        .wrap       (wrap)
    );

    // A held request acks once; it must be seen low before it can fire again.
    assign sw_go = sw_upd_req_i && req_armed;

    // State register.
    always_ff @(posedge clk_psc_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and counter controls; software update beats stop, stop beats wrap.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        load       = 1'b0;
        run        = 1'b0;
        evt_next   = 1'b0;
        ovf_next   = 1'b0;
        ack_next   = 1'b0;
        armed_next = sw_upd_req_i ? req_armed : 1'b1;
        if (sw_go) begin
            clear      = 1'b1;
            load       = 1'b1;
            evt_next   = 1'b1;
            ack_next   = 1'b1;
            armed_next = 1'b0;
            if (state == STOP)
                state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt_en_i) begin
                        state_next = RUN;
                        clear      = 1'b1;
                        load       = 1'b1;
                        evt_next   = 1'b1;
                    end
                end
                RUN: begin
                    if (!cnt_en_i) begin
                        state_next = IDLE;
                    end else if (wrap) begin
                        clear    = 1'b1;
                        ovf_next = 1'b1;
                        if (!udis_i) begin
                            load     = 1'b1;
                            evt_next = 1'b1;
                        end
                        if (one_shot_i)
                            state_next = STOP;
                    end else begin
                        run = 1'b1;
                    end
                end
                STOP: begin
                    if (!cnt_en_i)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
        // A write landing on the committing edge stays pending for the next event.
        pend_next = cfg_wr_i || (upd_pending_o && !evt_next);
    end

    // Registered event, flag and handshake outputs.
    always_ff @(posedge clk_psc_i) begin
        if (!rst_n_i) begin
            update_event_o <= 1'b0;
            overflow_o     <= 1'b0;
            sw_upd_ack_o   <= 1'b0;
            upd_pending_o  <= 1'b0;
            req_armed      <= 1'b1;
        end else begin
            update_event_o <= evt_next;
            overflow_o     <= ovf_next;
            sw_upd_ack_o   <= ack_next;
            upd_pending_o  <= pend_next;
            req_armed      <= armed_next;
        end
    end

    assign running_o = (state == RUN);

endmodule
